// File: rtl/task_dispatcher_pkg.sv
// Shared definitions for the task dispatcher and the control register block:
// dispatcher FSM states, control address map bits and AXI response codes.
package task_dispatcher_pkg;

    // Stand-ins for the system-wide configuration values.
    localparam int AXI_DATA_WIDTH             = 32;
    localparam int AXI_ADDR_WIDTH             = 32;
    localparam int NUM_NODES_PROCESSING       = 4;
    localparam int NUM_NODES_PROCESSING_WIDTH = 2;

    localparam int PROG_BIT = 7;
    localparam int BUSY_BIT = 8;
    localparam int NODE_LSB = 2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_PICK,
        ST_WR,
        ST_WR_RESP
    } disp_state_e;

    function automatic logic [AXI_ADDR_WIDTH-1:0] ctrl_busy_addr(input logic [AXI_ADDR_WIDTH-1:0] base);
        return base | (AXI_ADDR_WIDTH'(1) << BUSY_BIT);
    endfunction

    function automatic logic [AXI_ADDR_WIDTH-1:0] ctrl_prog_addr(input logic [AXI_ADDR_WIDTH-1:0] base,
                                                                 input logic [AXI_ADDR_WIDTH-1:0] node);
        return base | (AXI_ADDR_WIDTH'(1) << PROG_BIT) | (node << NODE_LSB);
    endfunction

endpackage

// File: rtl/task_dispatcher_fifo.sv
// Task queue: power-of-two depth FIFO with a registered head word, so the
// oldest entry is always presented from a flop while the queue is non-empty.
module task_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [LVL_W-1:0] level_q;
    logic [WIDTH-1:0] head_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (level_q == LVL_W'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign head_o     = head_q;
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
            // The incoming word becomes the head when it lands in a queue that is,
            // or is about to become, otherwise empty.
            if (do_push && (empty_o || (level_q == LVL_W'(1) && do_pop))) begin
                head_q <= push_data_i;
            end else if (do_pop) begin
                head_q <= mem[rd_ptr_inc];
            end
        end
    end

endmodule

// File: rtl/task_dispatcher.sv
// Queues program offsets and launches each on the lowest-index idle node by
// polling the busy mask and writing the node's PROG register over AXI-lite.
module task_dispatcher
    import task_dispatcher_pkg::*;
#(
    parameter logic [AXI_ADDR_WIDTH-1:0] CTRL_BASE = 32'h0000_0000,
    parameter int QUEUE_DEPTH = 8,
    parameter int POLL_GAP    = 16,
    parameter int NUM_NODES   = NUM_NODES_PROCESSING,
    parameter int NODE_W      = NUM_NODES_PROCESSING_WIDTH
) (
    input  logic                          clk,
    input  logic                          res_n,
    input  logic                          task_valid,
    input  logic [AXI_DATA_WIDTH-1:0]     task_addr,
    output logic                          task_ready,
    output logic                          task_reject,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic [NUM_NODES-1:0]          node_busy,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_level,
    output logic [31:0]                   dispatched,
    output logic                          bus_err
);

    localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int GAP_W = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);

    disp_state_e                  state_q;
    logic [GAP_W-1:0]             gap_q;
    logic [NODE_W-1:0]            node_q;
    logic [NUM_NODES-1:0]         node_busy_q;
    logic [31:0]                  dispatched_q;
    logic                         bus_err_q;
    logic                         reject_q;
    logic                         arvalid_q;
    logic [AXI_ADDR_WIDTH-1:0]    araddr_q;
    logic                         rready_q;
    logic                         awvalid_q;
    logic [AXI_ADDR_WIDTH-1:0]    awaddr_q;
    logic                         wvalid_q;
    logic [AXI_DATA_WIDTH-1:0]    wdata_q;
    logic                         bready_q;

    logic                         fifo_push;
    logic                         fifo_pop;
    logic [AXI_DATA_WIDTH-1:0]    fifo_head;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [LVL_W-1:0]             fifo_level;
    logic                         pop_leaves_empty;
    logic                         free_found;
    logic [NODE_W-1:0]            free_idx;
    logic                         aw_done;
    logic                         w_done;
    logic                         rdata_unused;

    assign task_ready       = !fifo_full;
    assign fifo_push        = task_valid && task_ready && (task_addr != '0);
    assign fifo_pop         = (state_q == ST_WR_RESP) && m_axi_bvalid && (m_axi_bresp == RESP_OKAY);
    assign pop_leaves_empty = (fifo_level == LVL_W'(1)) && !fifo_push;
    assign aw_done          = !awvalid_q || m_axi_awready;
    assign w_done           = !wvalid_q || m_axi_wready;
    assign rdata_unused     = ^m_axi_rdata;

    task_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (AXI_DATA_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .res_n       (res_n),
        .push_i      (fifo_push),
        .push_data_i (task_addr),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    // Descending scan so the lowest idle index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_NODES - 1; i >= 0; i--) begin
            if (!node_busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = NODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q      <= ST_IDLE;
            gap_q        <= '0;
            node_q       <= '0;
            node_busy_q  <= '0;
            dispatched_q <= '0;
            bus_err_q    <= 1'b0;
            reject_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            wvalid_q     <= 1'b0;
            wdata_q      <= '0;
            bready_q     <= 1'b0;
        end else begin
            reject_q <= task_valid && task_ready && (task_addr == '0);
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty && gap_q == '0) begin
                        araddr_q  <= ctrl_busy_addr(CTRL_BASE);
                        arvalid_q <= 1'b1;
                        state_q   <= ST_RD_ADDR;
                    end else if (gap_q != '0) begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (m_axi_rresp != RESP_OKAY) begin
                            bus_err_q <= 1'b1;
                            gap_q     <= GAP_W'(POLL_GAP);
                            state_q   <= ST_IDLE;
                        end else begin
                            node_busy_q <= m_axi_rdata[NUM_NODES-1:0];
                            state_q     <= ST_PICK;
                        end
                    end
                end
                ST_PICK: begin
                    if (!free_found) begin
                        gap_q   <= GAP_W'(POLL_GAP);
                        state_q <= ST_IDLE;
                    end else begin
                        node_q    <= free_idx;
                        awaddr_q  <= ctrl_prog_addr(CTRL_BASE, AXI_ADDR_WIDTH'(free_idx));
                        wdata_q   <= fifo_head;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (m_axi_bresp == RESP_OKAY) begin
                            dispatched_q        <= dispatched_q + 32'd1;
                            node_busy_q[node_q] <= 1'b1;
                            if (pop_leaves_empty) begin
                                gap_q   <= '0;
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_PICK;
                            end
                        end else begin
                            // Head stays queued; the launch is retried after the poll gap.
                            bus_err_q <= 1'b1;
                            gap_q     <= GAP_W'(POLL_GAP);
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign task_reject   = reject_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign node_busy     = node_busy_q;
    assign queue_level   = fifo_level;
    assign dispatched    = dispatched_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher with a small AXI-lite control-slave model
// whose busy mask, stalls and error responses are steered from the stimulus.
module tb_task_dispatcher;

    localparam int POLL_GAP = 16;

    logic        clk = 1'b0;
    logic        res_n;
    logic        task_valid;
    logic [31:0] task_addr;
    logic        task_ready;
    logic        task_reject;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        rready;
    logic [3:0]  node_busy;
    logic [3:0]  queue_level;
    logic [31:0] dispatched;
    logic        bus_err;

    // Slave control (stimulus side) and slave state (model side)
    logic [31:0] busy_reg;
    logic        stall_ar;
    logic        stall_w;
    int          err_budget;
    int          n_err_done = 0;
    int          n_reads = 0;
    int          cyc = 0;
    int          ar_cyc = 0;
    int          r_cyc = 0;
    logic        aw_got;
    logic        w_got;
    logic [31:0] aw_lat;
    logic [31:0] w_lat;
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    logic [31:0] wlog_resp[$];

    int chk_cnt = 0;
    int pass_cnt = 0;
    int r_first;

    always #5 clk = ~clk;

    task_dispatcher dut (
        .clk           (clk),
        .res_n         (res_n),
        .task_valid    (task_valid),
        .task_addr     (task_addr),
        .task_ready    (task_ready),
        .task_reject   (task_reject),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (s_bresp),
        .m_axi_bvalid  (s_bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (s_rdata),
        .m_axi_rresp   (s_rresp),
        .m_axi_rvalid  (s_rvalid),
        .m_axi_rready  (rready),
        .node_busy     (node_busy),
        .queue_level   (queue_level),
        .dispatched    (dispatched),
        .bus_err       (bus_err)
    );

    assign arready = !stall_ar;
    assign awready = !stall_w;
    assign wready  = !stall_w;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= 2'b00;
            s_bvalid <= 1'b0;
            s_bresp  <= 2'b00;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            aw_lat   <= '0;
            w_lat    <= '0;
        end else begin
            if (arvalid && arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= busy_reg;
                s_rresp  <= 2'b00;
                ar_cyc   <= cyc;
            end
            if (s_rvalid && rready) begin
                s_rvalid <= 1'b0;
                n_reads  <= n_reads + 1;
                r_cyc    <= cyc;
                $display("[tb] cyc %0d AXI read  addr=%08h data=%08h", cyc, araddr, s_rdata);
            end
            if (awvalid && awready) begin
                aw_got <= 1'b1;
                aw_lat <= awaddr;
            end
            if (wvalid && wready) begin
                w_got <= 1'b1;
                w_lat <= wdata;
            end
            if (aw_got && w_got && !s_bvalid) begin
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
                s_bvalid <= 1'b1;
                if (n_err_done < err_budget) begin
                    s_bresp    <= 2'b10;
                    n_err_done <= n_err_done + 1;
                end else begin
                    s_bresp <= 2'b00;
                end
            end
            if (s_bvalid && bready) begin
                s_bvalid <= 1'b0;
                wlog_addr.push_back(aw_lat);
                wlog_data.push_back(w_lat);
                wlog_resp.push_back({30'd0, s_bresp});
                $display("[tb] cyc %0d AXI write addr=%08h data=%08h resp=%0d", cyc, aw_lat, w_lat, s_bresp);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        @(negedge clk);
        task_valid = 1'b1;
        task_addr  = a;
        @(negedge clk);
        task_valid = 1'b0;
        task_addr  = '0;
    endtask

    task automatic wait_disp(input int n);
        for (int i = 0; i < 400 && dispatched != 32'(n); i++) @(negedge clk);
        chk("dispatched", dispatched, 32'(n));
    endtask

    task automatic wait_reads(input int n);
        for (int i = 0; i < 400 && n_reads != n; i++) @(negedge clk);
        chk("n_reads", 32'(n_reads), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_n      = 1'b0;
        task_valid = 1'b0;
        task_addr  = '0;
        busy_reg   = '0;
        stall_ar   = 1'b0;
        stall_w    = 1'b0;
        err_budget = 0;
        repeat (3) @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst task_ready", 32'(task_ready), 1);
        chk("rst task_reject", 32'(task_reject), 0);
        chk("rst node_busy", 32'(node_busy), 0);
        chk("rst queue_level", 32'(queue_level), 0);
        chk("rst dispatched", dispatched, 0);
        chk("rst bus_err", 32'(bus_err), 0);
        chk("rst valids", {28'd0, arvalid, awvalid, wvalid, rready | bready}, 0);

        // Single launch onto an all-idle system
        push(32'h100);
        wait_disp(1);
        chk("t1 level", 32'(queue_level), 0);
        chk("t1 addr", wlog_addr[0], 32'h80);
        chk("t1 data", wlog_data[0], 32'h100);
        chk("t1 wstrb/prot", {24'd0, wstrb, 1'b0, awprot}, 32'hF0);
        chk("t1 node_busy", 32'(node_busy), 32'h1);
        chk("t1 reads", 32'(n_reads), 1);

        // Two tasks launched back-to-back from a single busy read
        busy_reg = 32'h1;
        push(32'h200);
        push(32'h300);
        wait_disp(3);
        chk("t2 addr0", wlog_addr[1], 32'h84);
        chk("t2 data0", wlog_data[1], 32'h200);
        chk("t2 addr1", wlog_addr[2], 32'h88);
        chk("t2 data1", wlog_data[2], 32'h300);
        chk("t2 reads", 32'(n_reads), 2);
        chk("t2 node_busy", 32'(node_busy), 32'h7);

        // All busy: re-poll after the gap, then node 0 is freed
        busy_reg = 32'hF;
        push(32'h400);
        wait_reads(3);
        r_first  = r_cyc;
        busy_reg = 32'hE;
        chk("t3 node_busy", 32'(node_busy), 32'hF);
        chk("t3 no write", 32'(wlog_addr.size()), 3);
        chk("t3 level", 32'(queue_level), 1);
        wait_disp(4);
        // rvalid edge -> PICK, then POLL_GAP+1 idle cycles, then RD_ADDR handshake
        chk("t3 repoll gap", 32'(ar_cyc - r_first), 32'(POLL_GAP + 3));
        chk("t3 addr", wlog_addr[3], 32'h80);
        chk("t3 data", wlog_data[3], 32'h400);
        chk("t3 reads", 32'(n_reads), 4);

        // Fill the queue while the busy read is stalled
        stall_ar = 1'b1;
        busy_reg = 32'h0;
        for (int i = 0; i < 7; i++) push(32'h500 + 32'(i) * 4);
        chk("t4 level7", 32'(queue_level), 7);
        push(32'h0);
        chk("t4 reject pulse", 32'(task_reject), 1);
        chk("t4 level after zero", 32'(queue_level), 7);
        push(32'h51C);
        chk("t4 reject cleared", 32'(task_reject), 0);
        chk("t4 ready full", 32'(task_ready), 0);
        chk("t4 level full", 32'(queue_level), 8);
        push(32'h520);
        chk("t4 ninth ignored", 32'(queue_level), 8);
        chk("t4 reads stalled", 32'(n_reads), 4);
        stall_ar = 1'b0;
        wait_disp(12);
        for (int i = 0; i < 8; i++) begin
            chk("t4 drain addr", wlog_addr[4 + i], 32'h80 + 32'(i % 4) * 4);
            chk("t4 drain data", wlog_data[4 + i], 32'h500 + 32'(i) * 4);
        end
        chk("t4 reads", 32'(n_reads), 6);
        chk("t4 level", 32'(queue_level), 0);

        // SLVERR on the PROG write, then a successful retry
        err_budget = 1;
        push(32'h600);
        for (int i = 0; i < 400 && bus_err !== 1'b1; i++) @(negedge clk);
        chk("t5 bus_err", 32'(bus_err), 1);
        chk("t5 still queued", 32'(queue_level), 1);
        chk("t5 dispatched held", dispatched, 12);
        wait_disp(13);
        chk("t5 level", 32'(queue_level), 0);
        chk("t5 writes", 32'(wlog_addr.size()), 14);
        chk("t5 err resp", wlog_resp[12], 2);
        chk("t5 retry addr", wlog_addr[13], 32'h80);
        chk("t5 retry data", wlog_data[13], 32'h600);
        chk("t5 bus_err sticky", 32'(bus_err), 1);

        // Reset while the PROG write is pending
        stall_w = 1'b1;
        push(32'h700);
        for (int i = 0; i < 100 && awvalid !== 1'b1; i++) @(negedge clk);
        chk("t6 awvalid up", 32'(awvalid), 1);
        res_n = 1'b0;
        #1;
        chk("t6 awvalid drop", 32'(awvalid), 0);
        chk("t6 wvalid drop", 32'(wvalid), 0);
        chk("t6 level rst", 32'(queue_level), 0);
        chk("t6 dispatched rst", dispatched, 0);
        chk("t6 bus_err rst", 32'(bus_err), 0);
        chk("t6 node_busy rst", 32'(node_busy), 0);
        repeat (2) @(negedge clk);
        stall_w = 1'b0;
        res_n   = 1'b1;
        repeat (30) @(negedge clk);
        chk("t6 idle arvalid", 32'(arvalid), 0);
        chk("t6 level", 32'(queue_level), 0);
        chk("t6 dispatched", dispatched, 0);
        chk("t6 ready", 32'(task_ready), 1);
        chk("t6 no write", 32'(wlog_addr.size()), 14);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
